// File: rtl/cpu_pkg.sv
// Constants and types shared between the fetch stage and the instruction decoder.
package cpu_pkg;

  localparam int INSTR_W = 24;
  localparam int ADDR_W  = 12;

  localparam logic [3:0] ADDRR = 4'h0;
  localparam logic [3:0] ADDRI = 4'h1;
  localparam logic [3:0] SUBRR = 4'h2;
  localparam logic [3:0] SUBRI = 4'h3;
  localparam logic [3:0] ANDRR = 4'h4;
  localparam logic [3:0] ORRR  = 4'h5;
  localparam logic [3:0] XORRR = 4'h6;
  localparam logic [3:0] LDI   = 4'h7;
  localparam logic [3:0] LD    = 4'h8;
  localparam logic [3:0] ST    = 4'h9;
  localparam logic [3:0] JMP   = 4'hA;
  localparam logic [3:0] JZ    = 4'hB;
  localparam logic [3:0] NOP   = 4'hC;
  localparam logic [3:0] RES1  = 4'hD;
  localparam logic [3:0] RES2  = 4'hE;
  localparam logic [3:0] RES3  = 4'hF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of fetched {pc, instr} packets; flush wins over push and pop.
module fetch_queue
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  fetch_pkt_t push_pkt,
  output logic [1:0] count,
  output fetch_pkt_t head
);

  fetch_pkt_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_pkt;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: program counter, issue control toward sync instruction memory, redirect/kill handling.
//   state | meaning
//   IDLE  | not issuing; queued and in-flight words still drain
//   RUN   | issuing one read per cycle while the queue has room
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redir_valid,
  input  logic [ADDR_W-1:0]  redir_pc
);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] issued_pc;
  logic              inflight;
  logic              kill;
  logic              issue;
  logic              pop;
  logic              push;
  logic [1:0]        count;
  logic [2:0]        occupancy;
  fetch_pkt_t        push_pkt;
  fetch_pkt_t        head;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fetch_en)  state_nxt = RUN;
      RUN:     if (!fetch_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign instr_valid = (count != 2'd0) & ~redir_valid;
  assign pop         = instr_valid & instr_ready;
  // Slots already spoken for, counting the one the decoder frees this cycle.
  assign occupancy   = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue       = (state == RUN) & fetch_en & ~redir_valid & (occupancy < 3'd2);
  assign imem_en     = issue;
  assign imem_addr   = pc;

  assign push     = inflight & ~kill;
  assign push_pkt = '{pc: issued_pc, instr: imem_rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      issued_pc <= RESET_PC;
      inflight  <= 1'b0;
      kill      <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) issued_pc <= pc;
      // The word landing during a redirect is dropped by the queue flush; kill
      // covers any response still arriving in the cycle after.
      if (redir_valid) begin
        pc   <= redir_pc;
        kill <= inflight;
      end else begin
        if (issue) pc <= pc + 1'b1;
        kill <= 1'b0;
      end
    end
  end

  fetch_queue u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (redir_valid),
    .push_pkt (push_pkt),
    .count    (count),
    .head     (head)
  );

  assign instr    = head.instr;
  assign instr_pc = head.pc;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 24-bit CPU, directly upstream of the instruction decoder. It holds the program counter and issues reads to a synchronous instruction memory. Fetched words, each tagged with its PC, are buffered in a 2-entry queue and handed to the decoder over a valid/ready handshake. It accepts PC redirects for JMP, discarding all younger fetched or in-flight instructions.

## Interface
- ADDR_W, 12, instruction address width; matches the 12-bit instr[19:8] memory field.
- INSTR_W, 24, instruction word width.
- RESET_PC, 0, first fetch address after reset.

- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- fetch_en  in  1  1 = issue fetches; 0 = stop issuing, but in-flight data still lands.
- imem_en  out  1  read strobe to instruction memory.
- imem_addr  out  ADDR_W  read address.
- imem_rdata  in  INSTR_W  read data, valid exactly 1 cycle after imem_en.
- instr_valid  out  1  head of queue is valid.
- instr_ready  in  1  decoder accepts head.
- instr  out  INSTR_W  instruction word to decoder.
- instr_pc  out  ADDR_W  address of instr.
- redir_valid  in  1  redirect request (JMP resolved downstream).
- redir_pc  in  ADDR_W  redirect target.

## Operation
- FSM states: IDLE and RUN.
  - Reset enters IDLE.
  - IDLE -> RUN when fetch_en=1.
  - RUN -> IDLE when fetch_en=0.
- Internal state:
  - pc register.
  - inflight bit: a read was issued last cycle.
  - kill bit: discard the arriving read.
  - 2-entry queue holding {pc, instr} pairs.
- Issue rule, in cycle N: issue when state=RUN, fetch_en=1, redir_valid=0, and count + inflight − pop < 2.
  - pop = instr_valid & instr_ready.
  - An issue drives imem_en=1 and imem_addr=pc, sets inflight, and increments pc.
- PC arithmetic: pc + 1 is modulo 2^ADDR_W, so 0xFFF wraps to 0x000.
- Response: when inflight=1 and kill=0, push {addr issued, imem_rdata} into the queue. When kill=1, drop the data and clear kill.
- Output:
  - instr_valid = (count != 0) & ~redir_valid. The combinational path from redir_valid is intentional.
  - instr and instr_pc present the queue head.
- Redirect, when redir_valid=1 in cycle N (highest priority):
  - The queue is cleared and no pop occurs.
  - pc ← redir_pc.
  - kill ← inflight.
  - No issue occurs in cycle N.
- Simultaneous push and pop in the same cycle are allowed; count is unchanged.
- Queue overflow is impossible by the issue rule. The bench asserts count ≤ 2 at all times.
- While fetch_en=0, the queue still drains to the decoder and pc holds.

## Timing
- Reset values:
  - imem_en=0, imem_addr=RESET_PC.
  - instr_valid=0, instr=0, instr_pc=0.
  - pc=RESET_PC; count, inflight and kill all 0.
- rst asserted mid-operation overrides redirect and in-flight data. The next-cycle response is dropped because inflight is cleared.
- First fetch: fetch_en=1 in the first cycle after rst falls gives IDLE→RUN at that edge. The issue occurs the next cycle (call it T), and instr_valid=1 at T+2.
- Fetch latency: issue at N, data pushed at the end of N+1, instr_valid at N+2.
- Throughput: with instr_ready held at 1, one instruction per cycle in steady state.
- Backpressure: with instr_ready=0, at most 2 words are buffered and issuing stops. Issuing resumes in the cycle the head is popped.
- Redirect penalty: redir_valid at N, issue at redir_pc at N+1, first new instr_valid at N+3.

## Structure
- Shared package cpu_pkg holds constants and types common with the decoder:
  - INSTR_W and ADDR_W.
  - The 4-bit opcode constants ADDRR through RES3.
  - A fetch_pkt_t struct {pc, instr}.
  - The FSM state enum for IDLE/RUN.
- One sub-module: fetch_queue, a 2-entry synchronous FIFO of fetch_pkt_t.
  - Ports: push, pop, flush, count, head.
  - flush takes priority over push and pop.
- Top level instr_fetch contains pc, FSM, issue rule and kill logic.

## Test plan
- Reset then fetch_en=1, memory word k = 0x100000+k, instr_ready=1 → instr_pc 0,1,2,… on consecutive cycles starting 2 cycles after first imem_en, with instr matching each word.
- instr_ready=0 for 5 cycles mid-stream → exactly 2 words buffered, imem_en low after the buffer fills, no word lost or duplicated when ready returns.
- redir_valid with redir_pc=0x040 while queue full and a read in flight → queued words and the in-flight word never appear; next accepted instr_pc=0x040 appears 3 cycles after redirect.
- Start with RESET_PC=0xFFE → instr_pc sequence 0xFFE, 0xFFF, 0x000, 0x001.
- fetch_en dropped with one read in flight → that word is delivered, then no further imem_en; raising fetch_en resumes at the next sequential pc.
- rst asserted for 1 cycle mid-stream with a read in flight → all outputs return to reset values, the stale response is not queued, and fetch restarts at RESET_PC.
